n8_pad_emulator: RTL and testbench

Emulates the N8 game controller, so the FPGA can stand in for a physical pad in place of the external controller. It responds to the latch/pulse strobes issued by an N8 reader (such as `n8_driver`) and answers on a serial data line with eight button bits. Latch and pulse are asynchronous to `clk`; both pass through synchronizers and edge detectors. Used for loopback bench testing of the maze game and for scripted-input demos driven from switches.

---
 rtl/n8_pkg.sv | 24 ++
 rtl/sync_edge.sv | 33 +++
 rtl/n8_pad_emulator.sv | 109 ++++++++++
 tb/tb_n8_pad_emulator.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/n8_pkg.sv
// Shared constants and types for the N8 controller blocks (pad emulator and reader).
package n8_pkg;

  localparam int N8_A      = 0;
  localparam int N8_B      = 1;
  localparam int N8_SELECT = 2;
  localparam int N8_START  = 3;
  localparam int N8_UP     = 4;
  localparam int N8_DOWN   = 5;
  localparam int N8_LEFT   = 6;
  localparam int N8_RIGHT  = 7;

  localparam int N8_FRAME_BITS = 8;
  // Bit index must also hold the value 8 once the last bit has been shifted out.
  localparam int N8_IDX_W      = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } n8_pad_state_t;

endpackage

// File: rtl/sync_edge.sv
// Multi-stage synchronizer for an asynchronous strobe, with rising/falling edge
// flags derived from the synchronized level and its registered copy.
module sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], in};
      prev_q <= sync_q[STAGES-1];
    end
  end

  // Edges are decoded straight from flops so the FSM can act one cycle after
  // the level settles, keeping input-to-output latency at STAGES+1.
  assign level = sync_q[STAGES-1];
  assign rise  = sync_q[STAGES-1] & ~prev_q;
  assign fall  = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/n8_pad_emulator.sv
// Stands in for a physical N8 pad: answers the reader's latch/pulse strobes with
// eight active-low button bits on data_out, and counts completed frames.
module n8_pad_emulator
  import n8_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int COUNT_W     = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [7:0]          buttons,
  input  logic                ltch,
  input  logic                pulse,
  output logic                data_out,
  output logic                frame_done,
  output logic [COUNT_W-1:0]  frame_count,
  output logic                overrun,
  output n8_pad_state_t       dbg_state,
  output logic [N8_IDX_W-1:0] dbg_index
);

  localparam logic [N8_IDX_W-1:0] LAST_IDX = N8_IDX_W'(N8_FRAME_BITS - 1);

  logic ltch_s, ltch_rise, ltch_fall;
  logic pulse_s_unused, pulse_rise, pulse_fall_unused;

  sync_edge #(.STAGES(SYNC_STAGES)) u_ltch_sync (
    .clk   (clk),
    .reset (reset),
    .in    (ltch),
    .level (ltch_s),
    .rise  (ltch_rise),
    .fall  (ltch_fall)
  );

  sync_edge #(.STAGES(SYNC_STAGES)) u_pulse_sync (
    .clk   (clk),
    .reset (reset),
    .in    (pulse),
    .level (pulse_s_unused),
    .rise  (pulse_rise),
    .fall  (pulse_fall_unused)
  );

  n8_pad_state_t              state_q;
  logic [N8_FRAME_BITS-1:0]   shift_q;
  logic [N8_IDX_W-1:0]        index_q;
  logic                       data_q;
  logic                       done_q;
  logic [COUNT_W-1:0]         count_q;
  logic                       overrun_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      index_q   <= '0;
      data_q    <= 1'b1;
      done_q    <= 1'b0;
      count_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      done_q <= 1'b0;

      // Clear beats set when a new latch coincides with a stray pulse.
      if (ltch_rise)
        overrun_q <= 1'b0;
      else if (state_q == DONE && !ltch_s && pulse_rise)
        overrun_q <= 1'b1;

      // A high latch wins from every state, so an interrupted frame simply restarts.
      if (ltch_s) begin
        state_q <= LOAD;
        shift_q <= ~buttons;
        index_q <= '0;
        data_q  <= ~buttons[N8_A];
      end else begin
        case (state_q)
          IDLE: data_q <= 1'b1;
          LOAD: if (ltch_fall) state_q <= SHIFT;
          SHIFT: begin
            if (pulse_rise) begin
              shift_q <= {1'b1, shift_q[N8_FRAME_BITS-1:1]};
              index_q <= index_q + N8_IDX_W'(1);
              if (index_q == LAST_IDX) begin
                data_q  <= 1'b1;
                done_q  <= 1'b1;
                count_q <= count_q + COUNT_W'(1);
                state_q <= DONE;
              end else begin
                data_q <= shift_q[1];
              end
            end
          end
          DONE: data_q <= 1'b1;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign data_out    = data_q;
  assign frame_done  = done_q;
  assign frame_count = count_q;
  assign overrun     = overrun_q;
  assign dbg_state   = state_q;
  assign dbg_index   = index_q;

endmodule

// File: tb/tb_n8_pad_emulator.sv
// Bench for n8_pad_emulator: directed reader strobes, a queue-based model of the
// serial frame checked every settled cycle, and literal checks of known frames.
module tb_n8_pad_emulator;
  import n8_pkg::*;

  localparam int SYNC   = 2;
  localparam int CW     = 4;
  localparam int SETTLE = SYNC + 1;
  localparam int HALF   = SYNC + 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [7:0]    buttons;
  logic          ltch;
  logic          pulse;
  logic          data_out;
  logic          frame_done;
  logic [CW-1:0] frame_count;
  logic          overrun;
  n8_pad_state_t dbg_state;
  logic [3:0]    dbg_index;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc      = 0;
  int edge_cyc = 0;
  int dut_done = 0;

  // Frame model: the bits still to be presented, front = bit on the wire now.
  typedef enum {M_IDLE, M_LOADING, M_SHIFTING, M_SPENT} mphase_t;
  mphase_t    m_phase;
  logic [0:0] exp_q[$];
  int         m_count;
  int         m_done;
  logic       m_overrun;

  n8_pad_emulator #(.SYNC_STAGES(SYNC), .COUNT_W(CW)) dut (
    .clk         (clk),
    .reset       (reset),
    .buttons     (buttons),
    .ltch        (ltch),
    .pulse       (pulse),
    .data_out    (data_out),
    .frame_done  (frame_done),
    .frame_count (frame_count),
    .overrun     (overrun),
    .dbg_state   (dbg_state),
    .dbg_index   (dbg_index)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_phase = M_IDLE;
    exp_q.delete();
    m_count = 0;
    m_overrun = 1'b0;
  endtask

  task automatic model_load();
    exp_q.delete();
    for (int i = 0; i < 8; i++) exp_q.push_back(~buttons[i]);
  endtask

  function automatic logic m_data_exp();
    if ((m_phase == M_LOADING || m_phase == M_SHIFTING) && exp_q.size() > 0)
      return exp_q[0][0];
    return 1'b1;
  endfunction

  task automatic model_ltch(input logic v);
    if (v) begin
      m_overrun = 1'b0;
      m_phase = M_LOADING;
      model_load();
    end else if (m_phase == M_LOADING) begin
      m_phase = M_SHIFTING;
    end
  endtask

  task automatic model_pulse_rise();
    if (m_phase == M_SHIFTING) begin
      void'(exp_q.pop_front());
      if (exp_q.size() == 0) begin
        m_count++;
        m_done++;
        m_phase = M_SPENT;
      end
    end else if (m_phase == M_SPENT) begin
      m_overrun = 1'b1;
    end
  endtask

  // Compare process: every cycle once the last input edge has had time to land.
  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    if (!reset) begin
      if (frame_done === 1'b1) dut_done++;
      if (cyc - edge_cyc >= SETTLE) begin
        check("data_out", {31'd0, data_out}, {31'd0, m_data_exp()});
        check("frame_count", {28'd0, frame_count}, m_count % (1 << CW));
        check("overrun", {31'd0, overrun}, {31'd0, m_overrun});
        check("frame_done_total", dut_done, m_done);
      end
    end
  end

  task automatic set_buttons(input logic [7:0] v);
    buttons = v;
    if (m_phase == M_LOADING && ltch) begin
      model_load();
      edge_cyc = cyc;
    end
  endtask

  task automatic drive_ltch(input logic v);
    @(negedge clk);
    ltch = v;
    edge_cyc = cyc;
    model_ltch(v);
  endtask

  task automatic drive_pulse(input logic v);
    @(negedge clk);
    pulse = v;
    edge_cyc = cyc;
    if (v && !ltch) model_pulse_rise();
  endtask

  task automatic drive_both(input logic v);
    @(negedge clk);
    ltch = v;
    pulse = v;
    edge_cyc = cyc;
    model_ltch(v);
  endtask

  task automatic latch_frame(input int hi, output logic s);
    drive_ltch(1'b1);
    repeat (hi - 1) @(negedge clk);
    drive_ltch(1'b0);
    repeat (HALF - 1) @(negedge clk);
    s = data_out;
  endtask

  task automatic do_pulse(output logic s);
    drive_pulse(1'b1);
    repeat (HALF - 1) @(negedge clk);
    s = data_out;
    drive_pulse(1'b0);
    repeat (HALF - 1) @(negedge clk);
  endtask

  task automatic run_frame(input logic [7:0] b, output logic [7:0] seq, output logic tail);
    logic s;
    set_buttons(b);
    latch_frame(HALF, s);
    seq[0] = s;
    for (int i = 1; i <= 8; i++) begin
      do_pulse(s);
      if (i < 8) seq[i] = s;
      else tail = s;
    end
  endtask

  initial begin
    logic       s;
    logic       tail;
    logic [7:0] seq;
    int         d0;

    reset = 1'b1;
    ltch = 1'b0;
    pulse = 1'b0;
    buttons = 8'h00;
    m_done = 0;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_data_out", {31'd0, data_out}, 32'd1);
    check("rst_frame_done", {31'd0, frame_done}, 32'd0);
    check("rst_frame_count", {28'd0, frame_count}, 32'd0);
    check("rst_overrun", {31'd0, overrun}, 32'd0);
    check("rst_state", {30'd0, dbg_state}, {30'd0, IDLE});
    check("rst_index", {28'd0, dbg_index}, 32'd0);
    reset = 1'b0;
    edge_cyc = cyc;
    repeat (2) @(negedge clk);

    // Basic frame: A and start pressed.
    run_frame(8'h09, seq, tail);
    check("t1_seq", {24'd0, seq}, 32'hF6);
    check("t1_tail", {31'd0, tail}, 32'd1);
    check("t1_count", {28'd0, frame_count}, 32'd1);
    check("t1_done", dut_done, 32'd1);

    // Ten pulses after one latch: extra bits read 1 and overrun sticks.
    set_buttons(8'h09);
    latch_frame(HALF, s);
    for (int i = 1; i <= 10; i++) begin
      do_pulse(s);
      if (i >= 9) check("t2_extra_bit", {31'd0, s}, 32'd1);
    end
    check("t2_overrun", {31'd0, overrun}, 32'd1);
    check("t2_count", {28'd0, frame_count}, 32'd2);
    drive_ltch(1'b1);
    repeat (HALF - 1) @(negedge clk);
    check("t2_overrun_clr", {31'd0, overrun}, 32'd0);
    drive_ltch(1'b0);
    repeat (HALF - 1) @(negedge clk);

    // Abort after 3 pulses; buttons change while the latch is high.
    for (int i = 0; i < 3; i++) do_pulse(s);
    drive_ltch(1'b1);
    repeat (2) @(negedge clk);
    set_buttons(8'h80);
    repeat (3) @(negedge clk);
    drive_ltch(1'b0);
    repeat (HALF - 1) @(negedge clk);
    check("t3_no_done", dut_done, 32'd2);
    seq[0] = data_out;
    for (int i = 1; i <= 8; i++) begin
      do_pulse(s);
      if (i < 8) seq[i] = s;
      else tail = s;
    end
    check("t3_seq", {24'd0, seq}, 32'h7F);
    check("t3_tail", {31'd0, tail}, 32'd1);
    check("t3_count", {28'd0, frame_count}, 32'd3);
    check("t3_done", dut_done, 32'd3);

    // Latch and pulse rise together: pulse ignored.
    set_buttons(8'h01);
    drive_both(1'b1);
    repeat (HALF - 1) @(negedge clk);
    check("t4_index_hi", {28'd0, dbg_index}, 32'd0);
    check("t4_data_hi", {31'd0, data_out}, 32'd0);
    drive_both(1'b0);
    repeat (HALF - 1) @(negedge clk);
    check("t4_index", {28'd0, dbg_index}, 32'd0);
    check("t4_state", {30'd0, dbg_state}, {30'd0, SHIFT});
    seq[0] = data_out;
    for (int i = 1; i <= 8; i++) begin
      do_pulse(s);
      if (i < 8) seq[i] = s;
    end
    check("t4_seq", {24'd0, seq}, 32'hFE);
    check("t4_count", {28'd0, frame_count}, 32'd4);

    // Asynchronous reset in the middle of a frame at index 4.
    set_buttons(8'h09);
    latch_frame(HALF, s);
    for (int i = 0; i < 4; i++) do_pulse(s);
    check("t5_index_pre", {28'd0, dbg_index}, 32'd4);
    @(negedge clk);
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    check("t5_data_out", {31'd0, data_out}, 32'd1);
    check("t5_overrun", {31'd0, overrun}, 32'd0);
    check("t5_count", {28'd0, frame_count}, 32'd0);
    check("t5_index", {28'd0, dbg_index}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    edge_cyc = cyc;
    for (int i = 0; i < 3; i++) begin
      do_pulse(s);
      check("t5_ignored_pulse", {31'd0, s}, 32'd1);
    end
    check("t5_state_idle", {30'd0, dbg_state}, {30'd0, IDLE});
    check("t5_count_idle", {28'd0, frame_count}, 32'd0);
    run_frame(8'h09, seq, tail);
    check("t5_seq", {24'd0, seq}, 32'hF6);
    check("t5_count_after", {28'd0, frame_count}, 32'd1);

    // Counter wrap at all-ones (narrow counter instance).
    while (m_count != (1 << CW) - 1) run_frame(8'h5A, seq, tail);
    check("t6_count_full", {28'd0, frame_count}, 32'hF);
    d0 = dut_done;
    run_frame(8'hA5, seq, tail);
    check("t6_seq", {24'd0, seq}, 32'h5A);
    check("t6_count_wrap", {28'd0, frame_count}, 32'd0);
    check("t6_done", dut_done - d0, 32'd1);

    repeat (4) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
